regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter XLEN, default 64, data width in bits.
REQ-002 SHALL provide parameter NREG, default 32, number of registers (power of two, 2..256).
REQ-003 SHALL provide parameter AW, default 5, address width, equal to log2(NREG).
REQ-004 SHALL provide parameter ZERO_R0, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL provide port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL provide ports we0, we1  input  1  write enables, write ports 0 and 1.
REQ-008 SHALL provide ports wa0, wa1  input  AW  write addresses.
REQ-009 SHALL provide ports wd0, wd1  input  XLEN  write data.
REQ-010 SHALL provide ports ra0, ra1  input  AW  read addresses, sampled every cycle.
REQ-011 SHALL provide ports rd0, rd1  output  XLEN  registered read data.
REQ-012 SHALL provide port ready  output  1  high when clear sequence is done and writes are accepted.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 In CLEAR, SHALL zero one register per cycle, at index clr_cnt, with clr_cnt counting 0..NREG-1.
REQ-015 SHALL move from CLEAR to RUN on the cycle after clr_cnt = NREG-1 is cleared; the full clear takes exactly NREG cycles.
REQ-016 SHALL hold ready = 0 in CLEAR and ready = 1 in RUN.
REQ-017 SHALL ignore we0/we1 in CLEAR.
REQ-018 In CLEAR, SHALL drive rd0/rd1 to 0 on the following cycle.
REQ-019 In RUN, on each edge, SHALL write wd0 to wa0 when we0 is set, and wd1 to wa1 when we1 is set.
REQ-020 If we0 and we1 are both set with wa0 == wa1, SHALL store wd1 (port 1 priority).
REQ-021 If ZERO_R0 = 1, SHALL drop writes to address 0 and return 0 for reads of address 0.
REQ-022 SHALL have one-cycle read latency: rd0 on the edge after ra0 is presented.
REQ-023 SHALL bypass same-cycle writes to reads: if ra0/ra1 match an enabled write address in the same cycle, rd returns the new data, with port-1 priority per REQ-020 and REQ-021 still applied.
REQ-024 SHALL let reads return the stored value when there is no write match.
REQ-025 SHALL support both read ports reading the same address in the same cycle, both returning identical data.
REQ-026 SHALL store written data unmodified to XLEN bits, with no sign extension or truncation.
REQ-027 SHALL let reset asserted mid-CLEAR restart the clear from clr_cnt = 0.
REQ-028 SHALL let reset asserted in RUN abandon any same-cycle write; that write does not occur.

Reset
REQ-029 On a reset edge, SHALL set state = CLEAR, clr_cnt = 0, ready = 0, rd0 = 0, rd1 = 0.
REQ-030 SHALL hold state = CLEAR while reset is high; the clear counts from the first cycle after reset deasserts.
REQ-031 SHALL reach all-registers-zero only by the clear sequence; no initial-block preload is required.

Verification
REQ-032 Bench SHALL cover clear timing: deassert reset, count cycles -> ready rises exactly NREG (32) cycles later; reads of reg 31 return 0 before and after.
REQ-033 Bench SHALL cover write-then-read: we0 = 1, wa0 = 5, wd0 = 64'hDEAD_BEEF; next cycle ra0 = 5 -> rd0 = 64'hDEAD_BEEF one cycle later.
REQ-034 Bench SHALL cover the write collision: we0 = we1 = 1, wa0 = wa1 = 7, wd0 = 1, wd1 = 2 -> read of reg 7 returns 2; with ra1 = 7 in the same cycle, bypass gives rd1 = 2.
REQ-035 Bench SHALL cover register 0: write 64'hFFFF to address 0 -> rd0 for ra0 = 0 is 0, both in the same cycle (bypass) and later.
REQ-036 Bench SHALL cover writes during CLEAR: we0 = 1, wa0 = 3, wd0 = 9 at clear cycle 10 -> after ready, reg 3 reads 0.
REQ-037 Bench SHALL cover reset mid-clear: assert reset at clear cycle 20 -> ready stays 0 for a further full 32 cycles after deassert; reg 31 reads 0 after ready.

Source files
------------

// File: rtl/regfile_mp.sv
// Two-write, two-read register file with a post-reset clear sequence that
// zeroes one register per cycle before accepting writes.
module regfile_mp #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we0,
    input  logic            we1,
    input  logic [AW-1:0]   wa0,
    input  logic [AW-1:0]   wa1,
    input  logic [XLEN-1:0] wd0,
    input  logic [XLEN-1:0] wd1,
    input  logic [AW-1:0]   ra0,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] rd0,
    output logic [XLEN-1:0] rd1,
    output logic            ready
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]      state_reg;
    logic [AW-1:0]   clr_cnt_reg;
    logic [XLEN-1:0] mem [NREG];

    logic            run;
    logic            wen0;
    logic            wen1;
    logic [AW-1:0]   ra [2];
    logic [XLEN-1:0] rd_next [2];
    logic [XLEN-1:0] rd_reg [2];

    assign run   = (state_reg == S_RUN);
    assign ready = run;

    // Writes to r0 are dropped at the source so the bypass path sees them too.
    assign wen0 = run && !reset && we0 && !((ZERO_R0 != 0) && (wa0 == '0));
    assign wen1 = run && !reset && we1 && !((ZERO_R0 != 0) && (wa1 == '0));

    assign ra[0] = ra0;
    assign ra[1] = ra1;
    assign rd0   = rd_reg[0];
    assign rd1   = rd_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_CLEAR;
            clr_cnt_reg <= '0;
        end else if (!run) begin
            clr_cnt_reg <= clr_cnt_reg + AW'(1);
            if (clr_cnt_reg == AW'(NREG - 1)) begin
                state_reg <= S_RUN;
            end
        end
    end

    // Storage has no reset; it reaches a known state only through the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!run) begin
                mem[clr_cnt_reg] <= '0;
            end else begin
                if (wen0) begin
                    mem[wa0] <= wd0;
                end
                if (wen1) begin
                    mem[wa1] <= wd1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            // Port 1 is checked first so it wins an address collision.
            always_comb begin
                rd_next[gi] = mem[ra[gi]];
                if ((ZERO_R0 != 0) && (ra[gi] == '0)) begin
                    rd_next[gi] = '0;
                end else if (wen1 && (wa1 == ra[gi])) begin
                    rd_next[gi] = wd1;
                end else if (wen0 && (wa0 == ra[gi])) begin
                    rd_next[gi] = wd0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset || !run) begin
                    rd_reg[gi] <= '0;
                end else begin
                    rd_reg[gi] <= rd_next[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp: a per-cycle compare against a
// behavioural array model, plus literal checks for the key scenarios.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            we0, we1;
    logic [AW-1:0]   wa0, wa1, ra0, ra1;
    logic [XLEN-1:0] wd0, wd1;
    logic [XLEN-1:0] rd0, rd1;
    logic            ready;

    int n_vec;
    int n_bad;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .ZERO_R0(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1),
        .wd0(wd0), .wd1(wd1), .ra0(ra0), .ra1(ra1),
        .rd0(rd0), .rd1(rd1), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counts clear cycles, then behaves as an array whose
    // reads see the post-write contents (which is exactly what bypass means).
    logic [XLEN-1:0] model_mem [NREG];
    int              model_clr;
    logic            model_ready;
    logic [XLEN-1:0] exp_rd0, exp_rd1;
    logic            chk_en;

    initial begin
        chk_en      = 1'b0;
        model_clr   = 0;
        model_ready = 1'b0;
        exp_rd0     = '0;
        exp_rd1     = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            model_clr   = 0;
            model_ready = 1'b0;
            exp_rd0     = '0;
            exp_rd1     = '0;
            chk_en      = 1'b1;
        end else if (!model_ready) begin
            exp_rd0   = '0;
            exp_rd1   = '0;
            model_clr = model_clr + 1;
            if (model_clr == NREG) begin
                model_ready = 1'b1;
                for (int i = 0; i < NREG; i++) model_mem[i] = '0;
            end
        end else begin
            if (we0 && wa0 != 0) model_mem[wa0] = wd0;
            if (we1 && wa1 != 0) model_mem[wa1] = wd1;
            exp_rd0 = (ra0 == 0) ? '0 : model_mem[ra0];
            exp_rd1 = (ra1 == 0) ? '0 : model_mem[ra1];
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_vec = n_vec + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ready", {63'd0, ready}, {63'd0, model_ready});
            check("model_rd0", rd0, exp_rd0);
            check("model_rd1", rd1, exp_rd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    endtask

    // Counts edges after reset release until ready; optionally pokes a write
    // into reg 3 at clear cycle 10.
    task automatic wait_ready(input string name, input bit poke, output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            idle();
            if (poke && cycles == 9) begin
                we0 = 1'b1; wa0 = 5'd3; wd0 = 64'd9;
            end
            step();
            cycles++;
        end
        idle();
        check(name, 64'(cycles), 64'(NREG));
    endtask

    int cyc;

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle();
        ra0 = 5'd31; ra1 = 5'd31;
        reset = 1'b1;
        step(); step();
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_rd0", rd0, 64'd0);
        reset = 1'b0;

        // Clear timing, with reg 31 read during and after the clear.
        step();
        cyc = 1;
        check("clear_rd31_during", rd0, 64'd0);
        while (!ready && cyc < 200) begin
            step();
            cyc++;
        end
        check("clear_cycles", 64'(cyc), 64'(NREG));
        step();
        check("clear_rd31_after", rd0, 64'd0);

        // Write then read.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 64'hDEAD_BEEF;
        step();
        idle();
        ra0 = 5'd5;
        step();
        check("wr_rd5", rd0, 64'hDEAD_BEEF);

        // Both read ports on the same address.
        ra0 = 5'd5; ra1 = 5'd5;
        step();
        check("same_addr_rd0", rd0, 64'hDEAD_BEEF);
        check("same_addr_rd1", rd1, 64'hDEAD_BEEF);

        // Collision with same-cycle bypass on port 1.
        we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 64'd1; wd1 = 64'd2;
        ra1 = 5'd7;
        step();
        check("collide_bypass_rd1", rd1, 64'd2);
        idle();
        ra0 = 5'd7;
        step();
        check("collide_rd7", rd0, 64'd2);

        // Register 0 writes are dropped, also on the bypass path.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 64'hFFFF; ra0 = 5'd0;
        step();
        check("r0_bypass", rd0, 64'd0);
        idle();
        step();
        check("r0_later", rd0, 64'd0);

        // Full-width data with top bit set stored unmodified.
        we1 = 1'b1; wa1 = 5'd12; wd1 = 64'h8000_0000_0000_0001;
        step();
        idle();
        ra1 = 5'd12;
        step();
        check("full_width", rd1, 64'h8000_0000_0000_0001);

        // Write attempted during clear is ignored.
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready("clear_write_cycles", 1'b1, cyc);
        ra0 = 5'd3;
        step();
        check("clear_write_ignored", rd0, 64'd0);

        // Reset mid-clear restarts the full clear.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("midclear_not_ready", {63'd0, ready}, 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready("midclear_cycles", 1'b0, cyc);
        ra0 = 5'd31;
        step();
        check("midclear_rd31", rd0, 64'd0);

        // Randomized traffic with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            wa0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wa1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra0 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            ra1 = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd0 = {$urandom, $urandom};
            wd1 = {$urandom, $urandom};
            step();
        end
        reset = 1'b0;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
